// File: rtl/ic_mem_responder.sv
// Interconnect memory target: SRAM array, one-cycle read stage and an
// in-order response FIFO with credit-based grant back-pressure.
module ic_mem_responder #(
  parameter int    MEM_WORDS = 4096,
  parameter int    RSP_DEPTH = 2,
  parameter bit    READ_ONLY = 1'b0,
  parameter string INIT_FILE = ""
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        mem_req,
  input  logic        mem_wen,
  input  logic [3:0]  mem_strb,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_addr,
  output logic        mem_gnt,
  output logic        mem_recv,
  input  logic        mem_ack,
  output logic        mem_error,
  output logic [31:0] mem_rdata
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [CW-1:0] C_DEPTH = CW'(RSP_DEPTH);
  localparam logic [PW-1:0] P_ONE   = PW'(1);

  logic [31:0]   r_mem [MEM_WORDS];
  logic [31:0]   r_rd;
  logic          r_s1_v;
  logic          r_s1_wen;
  logic          r_s1_err;
  logic [31:0]   r_fd [RSP_DEPTH];
  logic          r_fe [RSP_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_out;

  logic [AW-1:0] w_idx;
  logic          w_err;
  logic          w_acc;
  logic          w_rd;
  logic          w_wr;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_pdata;
  logic          w_unused;

  function automatic logic [PW-1:0] f_next(
    input logic [PW-1:0] p
  );
    return (RSP_DEPTH == 1) ? '0 : p + P_ONE;
  endfunction

  // Upper address bits alias; range checks live in the decoder.
  assign w_unused = ^mem_addr;
  assign w_idx    = mem_addr[AW+1:2];

  assign w_err = (mem_addr[1:0] != 2'b00) ||
                 (READ_ONLY && mem_wen);

  // Grant sees only the registered credit count, never a same-cycle ack.
  assign mem_gnt = g_resetn && mem_req && (r_out < C_DEPTH);

  assign w_acc  = mem_req && mem_gnt;
  assign w_rd   = w_acc && !mem_wen;
  assign w_wr   = w_acc && mem_wen && !w_err;
  assign w_push = r_s1_v;
  assign w_pop  = mem_recv && mem_ack;

  assign w_pdata = (r_s1_wen || r_s1_err) ? '0 : r_rd;

  assign mem_recv  = (r_cnt != '0);
  assign mem_rdata = mem_recv ? r_fd[r_rptr] : '0;
  assign mem_error = mem_recv && r_fe[r_rptr];

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      r_s1_v <= 1'b0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_out  <= '0;
    end else begin
      r_s1_v <= w_acc;
      if (w_push) r_wptr <= f_next(r_wptr);
      if (w_pop)  r_rptr <= f_next(r_rptr);
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + C_ONE;
        2'b01:   r_cnt <= r_cnt - C_ONE;
        default: r_cnt <= r_cnt;
      endcase
      unique case ({w_acc, w_pop})
        2'b10:   r_out <= r_out + C_ONE;
        2'b01:   r_out <= r_out - C_ONE;
        default: r_out <= r_out;
      endcase
    end
  end

  always_ff @(posedge g_clk) begin
    r_s1_wen <= mem_wen;
    r_s1_err <= w_err;
    if (w_rd) r_rd <= r_mem[w_idx];
    if (w_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_strb[i])
          r_mem[w_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
    if (w_push) begin
      r_fd[r_wptr] <= w_pdata;
      r_fe[r_wptr] <= r_s1_err;
    end
  end

endmodule
